// File: rtl/tmds_decoder_if.sv
// Per-channel TMDS receive bus: the deserialized word in, decoded video/control and link status out.
// The decoder takes the slave view; whatever feeds it and consumes the results takes the master view.
interface tmds_decoder_if;
   logic [9:0] raw_in;
   logic [7:0] d_out;
   logic       de;
   logic [1:0] ctl;
   logic       locked;
   logic [3:0] slip_off;
   logic       disp_err;
   logic [7:0] err_cnt;

   modport master (
      output raw_in,
      input  d_out, de, ctl, locked, slip_off, disp_err, err_cnt
   );

   modport slave (
      input  raw_in,
      output d_out, de, ctl, locked, slip_off, disp_err, err_cnt
   );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word alignment on control-token runs, 10b->8b decode, link health; 2 cycles raw->out, no backpressure.
// Define TMDS_DEC_DISP_CHK_EN to build the running-disparity monitor (disp_err/err_cnt), otherwise both are tied to 0.
module tmds_decoder #(
   parameter int SEARCH_TMO = 64,
   parameter int LOCK_CNT   = 8,
   parameter int LOSS_TMO   = 4096,
   parameter int DISP_MAX   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   tmds_decoder_if.slave bus
);
   localparam int TMR_MAX = (LOSS_TMO > SEARCH_TMO) ? LOSS_TMO : SEARCH_TMO;
   localparam int TMR_W   = $clog2(TMR_MAX) + 1;
   localparam int TOK_W   = $clog2(LOCK_CNT) + 1;

   typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
   logic [3:0]         slip_off_q, slip_off_d, slip_next;
   logic [9:0]         prev_q, prev_d;
   logic [9:0]         a_q, a_d;
   logic [7:0]         d_out_q, d_out_d;
   logic               de_q, de_d;
   logic [1:0]         ctl_q, ctl_d;
   logic [19:0]        win_sh;
   logic               is_tok, out_en;
   logic [1:0]         tok_val;
   logic [7:0]         m, dec;

   // prev holds the older word, so it sits in the low half of the window
   always_comb begin
      win_sh    = {bus.raw_in, prev_q} >> slip_off_q;
      a_d       = win_sh[9:0];
      prev_d    = bus.raw_in;
      slip_next = (slip_off_q == 4'd9) ? 4'd0 : slip_off_q + 4'd1;
   end

   always_comb begin
      is_tok  = 1'b1;
      tok_val = 2'b00;
      case (a_q)
         10'b1101010100: tok_val = 2'b00;
         10'b0010101011: tok_val = 2'b01;
         10'b0101010100: tok_val = 2'b10;
         10'b1010101011: tok_val = 2'b11;
         default:        is_tok  = 1'b0;
      endcase
   end

   always_comb begin
      m      = a_q[9] ? ~a_q[7:0] : a_q[7:0];
      dec    = 8'd0;
      dec[0] = m[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = a_q[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      tok_cnt_d  = tok_cnt_q;
      slip_off_d = slip_off_q;
      case (state_q)
         ST_SEARCH: begin
            if (is_tok) begin
               state_d   = ST_VERIFY;
               tok_cnt_d = TOK_W'(1);
               timer_d   = '0;
            end else if (timer_q == TMR_W'(SEARCH_TMO - 1)) begin
               timer_d    = '0;
               slip_off_d = slip_next;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_VERIFY: begin
            if (is_tok) begin
               if (tok_cnt_q == TOK_W'(LOCK_CNT - 1)) begin
                  state_d   = ST_LOCKED;
                  tok_cnt_d = '0;
                  timer_d   = '0;
               end else begin
                  tok_cnt_d = tok_cnt_q + 1'b1;
               end
            end else begin
               state_d    = ST_SEARCH;
               slip_off_d = slip_next;
               tok_cnt_d  = '0;
               timer_d    = '0;
            end
         end
         ST_LOCKED: begin
            if (is_tok) begin
               timer_d = '0;
            end else if (timer_q == TMR_W'(LOSS_TMO - 1)) begin
               state_d   = ST_SEARCH;
               timer_d   = '0;
               tok_cnt_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d   = ST_SEARCH;
            timer_d   = '0;
            tok_cnt_d = '0;
         end
      endcase
   end

   // Outputs are qualified by the state being entered so they line up with 'locked'
   always_comb begin
      out_en  = (state_d == ST_LOCKED);
      d_out_d = d_out_q;
      de_d    = de_q;
      ctl_d   = ctl_q;
      if (!out_en) begin
         d_out_d = 8'd0;
         de_d    = 1'b0;
         ctl_d   = 2'b00;
      end else if (is_tok) begin
         de_d  = 1'b0;
         ctl_d = tok_val;
      end else begin
         de_d    = 1'b1;
         d_out_d = dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_SEARCH;
         timer_q    <= '0;
         tok_cnt_q  <= '0;
         slip_off_q <= 4'd0;
         prev_q     <= 10'd0;
         a_q        <= 10'd0;
         d_out_q    <= 8'd0;
         de_q       <= 1'b0;
         ctl_q      <= 2'b00;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         tok_cnt_q  <= tok_cnt_d;
         slip_off_q <= slip_off_d;
         prev_q     <= prev_d;
         a_q        <= a_d;
         d_out_q    <= d_out_d;
         de_q       <= de_d;
         ctl_q      <= ctl_d;
      end
   end

   assign bus.d_out    = d_out_q;
   assign bus.de       = de_q;
   assign bus.ctl      = ctl_q;
   assign bus.locked   = (state_q == ST_LOCKED);
   assign bus.slip_off = slip_off_q;

`ifdef TMDS_DEC_DISP_CHK_EN
   localparam logic signed [8:0] RD_LIM = 9'sd63;
   localparam logic signed [8:0] D_LIM  = 9'(DISP_MAX);

   logic signed [6:0] rd_q, rd_d;
   logic              disp_err_q, disp_err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [3:0]        pop;
   logic signed [8:0] rd_sum, rd_sat;

   always_comb begin
      rd_d       = rd_q;
      disp_err_d = 1'b0;
      err_cnt_d  = err_cnt_q;
      pop        = 4'($countones(a_q));
      rd_sum     = $signed({{2{rd_q[6]}}, rd_q}) + $signed({5'd0, pop}) - 9'sd5;
      if (rd_sum > RD_LIM)       rd_sat = RD_LIM;
      else if (rd_sum < -RD_LIM) rd_sat = -RD_LIM;
      else                       rd_sat = rd_sum;
      if (is_tok) begin
         rd_d = '0;
      end else if (out_en) begin
         if (rd_sat > D_LIM || rd_sat < -D_LIM) begin
            disp_err_d = 1'b1;
            rd_d       = '0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         end else begin
            rd_d = rd_sat[6:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q       <= '0;
         disp_err_q <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         rd_q       <= rd_d;
         disp_err_q <= disp_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.disp_err = disp_err_q;
   assign bus.err_cnt  = err_cnt_q;
`else
   assign bus.disp_err = 1'b0;
   assign bus.err_cnt  = 8'd0;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed alignment/lock scenarios plus a randomized encoded stream checked against a TMDS encoder model.
module tb_tmds_decoder;
   localparam int SEARCH_TMO = 64;
   localparam int LOCK_CNT   = 8;
   localparam int LOSS_TMO   = 4096;
   localparam int DISP_MAX   = 16;
   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] W_ONES = 10'b1111111111;
   localparam logic [9:0] W_P3   = 10'b1111111100;
`ifdef TMDS_DEC_DISP_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   edge_n = 0;
   int   enc_cnt = 0;

   tmds_decoder_if bus();

   tmds_decoder #(
      .SEARCH_TMO(SEARCH_TMO), .LOCK_CNT(LOCK_CNT), .LOSS_TMO(LOSS_TMO), .DISP_MAX(DISP_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic [9:0] w);
      bus.raw_in = w;
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic do_reset();
      bus.raw_in = 10'd0;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      edge_n = 0;
      enc_cnt = 0;
   endtask

   // Standard DVI TMDS data encoder with running disparity
   task automatic enc(input logic [7:0] d, output logic [9:0] q);
      logic [8:0] qm;
      int n1, n1q, n0q;
      n1 = $countones(d);
      qm = 9'd0;
      qm[0] = d[0];
      if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (enc_cnt == 0 || n1q == n0q) begin
         q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         if (qm[8]) enc_cnt += n1q - n0q;
         else       enc_cnt += n0q - n1q;
      end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.raw_in = 10'h2AA;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.d_out !== 8'd0)    begin failures++; $display("FAIL reset_d_out got=%h exp=00", bus.d_out); end
      checks++; if (bus.de !== 1'b0)       begin failures++; $display("FAIL reset_de got=%b exp=0", bus.de); end
      checks++; if (bus.ctl !== 2'b00)     begin failures++; $display("FAIL reset_ctl got=%b exp=00", bus.ctl); end
      checks++; if (bus.locked !== 1'b0)   begin failures++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
      checks++; if (bus.slip_off !== 4'd0) begin failures++; $display("FAIL reset_slip got=%0d exp=0", bus.slip_off); end
      checks++; if (bus.disp_err !== 1'b0) begin failures++; $display("FAIL reset_disp_err got=%b exp=0", bus.disp_err); end
      checks++; if (bus.err_cnt !== 8'd0)  begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", bus.err_cnt); end
   endtask

   task automatic test_aligned_lock();
      int lock_edge = -1;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cyc(T00);
         if (bus.locked === 1'b1 && lock_edge < 0) lock_edge = edge_n;
      end
      // first token lands in a_q at edge 2, then LOCK_CNT tokens are consumed
      checks++; if (lock_edge != 2 + LOCK_CNT) begin failures++; $display("FAIL aligned_lock_edge got=%0d exp=%0d", lock_edge, 2 + LOCK_CNT); end
      checks++; if (bus.ctl !== 2'b00 || bus.de !== 1'b0) begin failures++; $display("FAIL aligned_ctl_de got=%b/%b exp=00/0", bus.ctl, bus.de); end
      checks++; if (bus.slip_off !== 4'd0) begin failures++; $display("FAIL aligned_slip got=%0d exp=0", bus.slip_off); end
   endtask

   task automatic test_misaligned_lock();
      localparam int K = 3;
      localparam int NW = 220;
      int slip_edges[$];
      int lock_edge = -1;
      logic [3:0] last_slip = 4'd0;
      logic [9:0] w;
      int b;
      do_reset();
      for (int i = 0; i < NW; i++) begin
         for (int j = 0; j < 10; j++) begin
            b = 10 * i + j;
            w[j] = (b < K) ? 1'b0 : T00[(b - K) % 10];
         end
         cyc(w);
         if (bus.slip_off !== last_slip) begin
            slip_edges.push_back(edge_n);
            last_slip = bus.slip_off;
         end
         if (bus.locked === 1'b1 && lock_edge < 0) lock_edge = edge_n;
      end
      checks++; if (slip_edges.size() != K) begin failures++; $display("FAIL misalign_slip_steps got=%0d exp=%0d", slip_edges.size(), K); end
      if (slip_edges.size() == K) begin
         checks++; if (slip_edges[0] != SEARCH_TMO) begin failures++; $display("FAIL misalign_first_slip got=%0d exp=%0d", slip_edges[0], SEARCH_TMO); end
         for (int s = 1; s < K; s++) begin
            checks++; if (slip_edges[s] - slip_edges[s-1] != SEARCH_TMO) begin failures++; $display("FAIL misalign_slip_gap%0d got=%0d exp=%0d", s, slip_edges[s] - slip_edges[s-1], SEARCH_TMO); end
         end
         checks++; if (lock_edge != slip_edges[K-1] + 1 + LOCK_CNT) begin failures++; $display("FAIL misalign_lock_edge got=%0d exp=%0d", lock_edge, slip_edges[K-1] + 1 + LOCK_CNT); end
      end
      checks++; if (bus.slip_off !== 4'(K) || bus.locked !== 1'b1 || bus.ctl !== 2'b00) begin failures++; $display("FAIL misalign_final got slip=%0d lock=%b ctl=%b exp slip=%0d lock=1 ctl=00", bus.slip_off, bus.locked, bus.ctl, K); end
   endtask

   task automatic test_data_roundtrip();
      localparam int NR = 160;
      logic [9:0] sw[$];
      logic       sde[$];
      logic [7:0] sd[$];
      logic [1:0] sc[$];
      logic [7:0] fixed[4];
      logic [7:0] hold_d = 8'd0;
      logic [1:0] hold_c = 2'b00;
      logic [1:0] tv;
      logic [7:0] by;
      logic [9:0] w;
      logic [9:0] toks[4];
      int n;
      fixed = '{8'h00, 8'hFF, 8'h5A, 8'h10};
      toks = '{T00, T01, T10, T11};
      do_reset();
      for (int i = 0; i < 12; i++) cyc(T00);
      for (int i = 0; i < 4 + 1 + NR + 2; i++) begin
         if (i < 4 || (i >= 5 && i < 5 + NR && $urandom_range(3) != 0)) begin
            by = (i < 4) ? fixed[i] : 8'($urandom);
            enc(by, w);
            hold_d = by;
            sw.push_back(w); sde.push_back(1'b1);
         end else begin
            tv = (i == 4) ? 2'b11 : (i >= 5 + NR) ? 2'b00 : 2'($urandom);
            sw.push_back(toks[tv]); sde.push_back(1'b0);
            hold_c = tv;
         end
         sd.push_back(hold_d); sc.push_back(hold_c);
      end
      n = sw.size();
      for (int i = 0; i < n; i++) begin
         cyc(sw[i]);
         if (i >= 2) begin
            checks++;
            if (bus.locked !== 1'b1 || bus.de !== sde[i-2] || bus.d_out !== sd[i-2] || bus.ctl !== sc[i-2]) begin
               failures++;
               $display("FAIL stream_word%0d got lock=%b de=%b d=%h ctl=%b exp lock=1 de=%b d=%h ctl=%b",
                        i - 2, bus.locked, bus.de, bus.d_out, bus.ctl, sde[i-2], sd[i-2], sc[i-2]);
            end
         end
      end
   endtask

   task automatic test_verify_abort();
      logic [3:0] slip_at[1:20];
      bit ever_locked = 0;
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         cyc((i <= 4) ? T00 : W_ONES);
         slip_at[i] = bus.slip_off;
         if (bus.locked === 1'b1) ever_locked = 1;
      end
      checks++; if (slip_at[6] !== 4'd0) begin failures++; $display("FAIL abort_slip_before got=%0d exp=0", slip_at[6]); end
      checks++; if (slip_at[7] !== 4'd1) begin failures++; $display("FAIL abort_slip_after got=%0d exp=1", slip_at[7]); end
      checks++; if (slip_at[20] !== 4'd1) begin failures++; $display("FAIL abort_slip_hold got=%0d exp=1", slip_at[20]); end
      checks++; if (ever_locked) begin failures++; $display("FAIL abort_locked got=1 exp=0"); end
   endtask

   task automatic test_loss_of_lock();
      int start_e, fall_e = -1;
      logic [3:0] slip_fall = 4'hF;
      logic [9:0] w;
      do_reset();
      for (int i = 0; i < 12; i++) cyc(T00);
      start_e = edge_n + 1;
      for (int i = 0; i < LOSS_TMO + 10; i++) begin
         cyc(W_ONES);
         if (bus.locked !== 1'b1 && fall_e < 0) begin
            fall_e = edge_n;
            slip_fall = bus.slip_off;
         end
      end
      checks++; if (fall_e != start_e + 1 + LOSS_TMO) begin failures++; $display("FAIL loss_fall_edge got=%0d exp=%0d", fall_e, start_e + 1 + LOSS_TMO); end
      checks++; if (slip_fall !== 4'd0) begin failures++; $display("FAIL loss_slip_kept got=%0d exp=0", slip_fall); end
      checks++; if (bus.de !== 1'b0 || bus.d_out !== 8'd0) begin failures++; $display("FAIL loss_outputs got de=%b d=%h exp de=0 d=00", bus.de, bus.d_out); end
      // relock, push data, then pull reset between edges
      for (int i = 0; i < 12; i++) cyc(T00);
      enc_cnt = 0;
      for (int i = 0; i < 4; i++) begin enc(8'hFF, w); cyc(w); end
      checks++; if (bus.locked !== 1'b1 || bus.de !== 1'b1 || bus.d_out !== 8'hFF) begin failures++; $display("FAIL midrst_pre got lock=%b de=%b d=%h exp 1/1/ff", bus.locked, bus.de, bus.d_out); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.locked !== 1'b0 || bus.de !== 1'b0 || bus.d_out !== 8'd0 || bus.ctl !== 2'b00 ||
          bus.slip_off !== 4'd0 || bus.disp_err !== 1'b0 || bus.err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL midrst_async got lock=%b de=%b d=%h ctl=%b slip=%0d derr=%b ecnt=%0d exp all 0",
                  bus.locked, bus.de, bus.d_out, bus.ctl, bus.slip_off, bus.disp_err, bus.err_cnt);
      end
   endtask

   task automatic test_disparity();
      localparam int NP = 6;
      logic exp_err[NP];
      int rd = 0;
      int errs = 0;
      for (int i = 0; i < NP; i++) begin
         rd += $countones(W_P3) - 5;
         if (rd > 63) rd = 63;
         if (rd < -63) rd = -63;
         exp_err[i] = CHK && (rd > DISP_MAX || rd < -DISP_MAX);
         if (exp_err[i]) begin rd = 0; errs++; end
      end
      do_reset();
      for (int i = 0; i < 12; i++) cyc(T00);
      for (int i = 0; i < NP + 2; i++) begin
         cyc((i < NP) ? W_P3 : T00);
         if (i >= 2) begin
            checks++;
            if (bus.disp_err !== exp_err[i-2] || bus.de !== 1'b1) begin
               failures++;
               $display("FAIL disp_word%0d got err=%b de=%b exp err=%b de=1", i - 2, bus.disp_err, bus.de, exp_err[i-2]);
            end
         end
      end
      cyc(T00);
      checks++; if (bus.err_cnt !== 8'(errs) || bus.disp_err !== 1'b0) begin failures++; $display("FAIL disp_err_cnt got cnt=%0d err=%b exp cnt=%0d err=0", bus.err_cnt, bus.disp_err, errs); end
   endtask

   initial begin
      bus.raw_in = 10'd0;
      test_reset();
      test_aligned_lock();
      test_misaligned_lock();
      test_data_roundtrip();
      test_verify_abort();
      test_loss_of_lock();
      test_disparity();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
